// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Operand stage in front of the 2x2 PE systolic array. It buffers one K-step
// operand set from a valid/ready stream and replays it into the array's
// data/weight inputs. Row 1 data and column 1 weight lag by one cycle to give
// the array its diagonal skew. The operands are zero outside the valid window.
// systolic_en is held high through the feed and drain phases, and done pulses
// on the final drain cycle.
//
// Optional build macro: FEEDER_CYCLE_CNT_EN. When it is defined, the block
// adds a saturating 32-bit count of cycles with systolic_en=1.
//
// Ports
//   clk, rst             clock (rising edge) and async active-high reset
//   in_valid/in_ready    beat handshake; a beat moves when both are high
//   in_a                 {A[1][k], A[0][k]}
//   in_b                 {B[k][1], B[k][0]}
//   in_last              marks the final beat of a set
//   data_1/data_2        array row 0 / row 1 data inputs
//   weight_1/weight_2    array column 0 / column 1 weight inputs
//   systolic_en          high during FEED and DRAIN
//   busy                 high outside IDLE
//   done                 one-cycle pulse on the last DRAIN cycle
//   ovf                  sticky: the last set was truncated at DEPTH
//   cycle_cnt            (FEEDER_CYCLE_CNT_EN only) enabled-cycle counter
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | empty, waiting for the first beat of a set
// LOAD  | collecting beats 1..K-1
// FEED  | replaying the set, t = 0..K
// DRAIN | zero operands so the last products settle in the array
// -----------------------------------------------------------------------------
module systolic_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int DRAIN  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_a,
    input  logic [2*DATA_W-1:0] in_b,
    input  logic                in_last,
    output logic [DATA_W-1:0]   data_1,
    output logic [DATA_W-1:0]   data_2,
    output logic [DATA_W-1:0]   weight_1,
    output logic [DATA_W-1:0]   weight_2,
    output logic                systolic_en,
    output logic                busy,
    output logic                done,
    output logic                ovf
`ifdef FEEDER_CYCLE_CNT_EN
    ,
    output logic [31:0]         cycle_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FEED  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [CW-1:0] LAST_IDX   = CW'(DEPTH - 1);
    localparam logic [RW-1:0] DRAIN_INIT = RW'((DRAIN > 0) ? DRAIN - 1 : 0);

    logic [1:0]    state, state_n;
    logic [CW-1:0] k_cnt, k_n;
    logic [CW-1:0] t_cnt, t_n;
    logic [RW-1:0] dr_cnt, dr_n;
    logic          ovf_n, done_n;
    logic          hs;

    logic [DATA_W-1:0] a0_mem [0:(1<<IW)-1];
    logic [DATA_W-1:0] a1_mem [0:(1<<IW)-1];
    logic [DATA_W-1:0] b0_mem [0:(1<<IW)-1];
    logic [DATA_W-1:0] b1_mem [0:(1<<IW)-1];

    logic [IW-1:0]     rd_t, rd_tm1;
    logic              bypass;
    logic [DATA_W-1:0] d1_n, d2_n, w1_n, w2_n;

    assign hs = in_valid && in_ready;

    // Buffer contents need no reset; k_cnt is 0 in IDLE, so the first beat
    // of a set always lands at index 0.
    always_ff @(posedge clk) begin
        if (hs) begin
            a0_mem[k_cnt[IW-1:0]] <= in_a[DATA_W-1:0];
            a1_mem[k_cnt[IW-1:0]] <= in_a[2*DATA_W-1:DATA_W];
            b0_mem[k_cnt[IW-1:0]] <= in_b[DATA_W-1:0];
            b1_mem[k_cnt[IW-1:0]] <= in_b[2*DATA_W-1:DATA_W];
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k_cnt;
        t_n     = t_cnt;
        dr_n    = dr_cnt;
        ovf_n   = ovf;
        done_n  = 1'b0;
        bypass  = 1'b0;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    k_n   = CW'(1);
                    ovf_n = 1'b0;
                    if (in_last || (DEPTH == 1)) begin
                        state_n = S_FEED;
                        t_n     = '0;
                        ovf_n   = !in_last;
                        // A single-beat set is still being written, so the
                        // t=0 operands come from the input bus.
                        bypass  = 1'b1;
                    end else begin
                        state_n = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    k_n = k_cnt + CW'(1);
                    if (in_last || (k_cnt == LAST_IDX)) begin
                        state_n = S_FEED;
                        t_n     = '0;
                        ovf_n   = !in_last;
                    end
                end
            end
            S_FEED: begin
                if (t_cnt == k_cnt) begin
                    if (DRAIN == 0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        k_n     = '0;
                        t_n     = '0;
                    end else begin
                        state_n = S_DRAIN;
                        dr_n    = DRAIN_INIT;
                        done_n  = (DRAIN == 1);
                    end
                end else begin
                    t_n = t_cnt + CW'(1);
                end
            end
            default: begin
                if (dr_cnt == '0) begin
                    state_n = S_IDLE;
                    k_n     = '0;
                    t_n     = '0;
                end else begin
                    dr_n   = dr_cnt - RW'(1);
                    done_n = (dr_cnt == RW'(1));
                end
            end
        endcase
    end

    // The operands are computed for the next feed index, so the registered
    // outputs line up with the cycle in which state==FEED at that index.
    always_comb begin
        rd_t   = t_n[IW-1:0];
        rd_tm1 = rd_t - IW'(1);
        d1_n   = '0;
        d2_n   = '0;
        w1_n   = '0;
        w2_n   = '0;
        if (state_n == S_FEED) begin
            if (t_n < k_n) begin
                d1_n = bypass ? in_a[DATA_W-1:0] : a0_mem[rd_t];
                w1_n = bypass ? in_b[DATA_W-1:0] : b0_mem[rd_t];
            end
            if (t_n != '0) begin
                d2_n = a1_mem[rd_tm1];
                w2_n = b1_mem[rd_tm1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k_cnt       <= '0;
            t_cnt       <= '0;
            dr_cnt      <= '0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            systolic_en <= 1'b0;
            data_1      <= '0;
            data_2      <= '0;
            weight_1    <= '0;
            weight_2    <= '0;
        end else begin
            state       <= state_n;
            k_cnt       <= k_n;
            t_cnt       <= t_n;
            dr_cnt      <= dr_n;
            ovf         <= ovf_n;
            done        <= done_n;
            in_ready    <= (state_n == S_IDLE) || (state_n == S_LOAD);
            busy        <= (state_n != S_IDLE);
            systolic_en <= (state_n == S_FEED) || (state_n == S_DRAIN);
            data_1      <= d1_n;
            data_2      <= d2_n;
            weight_1    <= w1_n;
            weight_2    <= w2_n;
        end
    end

`ifdef FEEDER_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (systolic_en && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Randomized bench for systolic_feeder. Operand sets are generated in the
// bench. The expected skewed output trace is computed per set from the
// feeding rules: feed index t = 0..K, then DRAIN zero cycles, then IDLE.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2*DW-1:0] in_a, in_b;
    logic          in_last;
    logic [DW-1:0] data_1, data_2, weight_1, weight_2;
    logic          systolic_en, busy, done, ovf;
`ifdef FEEDER_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .data_1(data_1), .data_2(data_2),
        .weight_1(weight_1), .weight_2(weight_2),
        .systolic_en(systolic_en), .busy(busy), .done(done), .ovf(ovf)
`ifdef FEEDER_CYCLE_CNT_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    logic [DW-1:0] ba0 [DEPTH];
    logic [DW-1:0] ba1 [DEPTH];
    logic [DW-1:0] bb0 [DEPTH];
    logic [DW-1:0] bb1 [DEPTH];

    int     errors = 0;
    int     checks = 0;
    bit     ovf_exp = 1'b0;
    longint en_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            ba0[i] = DW'($urandom);
            ba1[i] = DW'($urandom);
            bb0[i] = DW'($urandom);
            bb1[i] = DW'($urandom);
        end
    endtask

    task automatic send_beat(input int i, input bit last, input int gap);
        int w;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_last  = 1'($urandom);
        repeat (gap) @(negedge clk);
        in_a     = {ba1[i], ba0[i]};
        in_b     = {bb1[i], bb0[i]};
        in_last  = last;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("handshake_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // n beats, the last one flagged if with_last; with_last=0 is only used
    // with n == DEPTH, i.e. a truncated set. abort_at > 0 pulses reset at
    // that cycle after the last beat.
    task automatic run_set(input int n, input bit with_last, input int mingap,
                           input int maxgap, input int abort_at);
        int k, dones, t, total;
        logic [63:0] e_ops;
        logic [4:0]  e_ctl;
        bit          set_ovf;
        k       = n;
        set_ovf = !with_last;
        total   = k + DRAIN + 2;
        chk("ovf_before", 64'(ovf), 64'(ovf_exp));
        for (int i = 0; i < n; i++) begin
            send_beat(i, with_last && (i == n - 1), $urandom_range(mingap, maxgap));
            ovf_exp = 1'b0;
            if (i < n - 1)
                chk("load_ctrl", {60'd0, busy, in_ready, systolic_en, ovf}, 64'b1100);
        end
        ovf_exp = set_ovf;
        dones   = 0;
        for (int j = 1; j <= total; j++) begin
            @(negedge clk);
            e_ops = '0;
            if (j <= k + 1) begin
                t = j - 1;
                if (t < k)  begin e_ops[63:48] = ba0[t];   e_ops[31:16] = bb0[t];   end
                if (t >= 1) begin e_ops[47:32] = ba1[t-1]; e_ops[15:0]  = bb1[t-1]; end
                e_ctl = {1'b0, 1'b1, 1'b1, 1'b0, ovf_exp};
            end else if (j <= k + 1 + DRAIN) begin
                e_ctl = {1'b0, 1'b1, 1'b1, (j == k + 1 + DRAIN), ovf_exp};
            end else begin
                e_ctl = {1'b1, 1'b0, 1'b0, (DRAIN == 0 && j == k + 2), ovf_exp};
            end
            chk("feed_ops", {data_1, data_2, weight_1, weight_2}, e_ops);
            chk("feed_ctrl", {59'd0, in_ready, systolic_en, busy, done, ovf}, {59'd0, e_ctl});
            if (done) dones++;
            if (j == abort_at) begin
                #3 rst = 1'b1;
                #1;
                chk("abort_ops", {data_1, data_2, weight_1, weight_2}, 64'd0);
                chk("abort_ctrl", {59'd0, in_ready, systolic_en, busy, done, ovf}, 64'd0);
                ovf_exp   = 1'b0;
                en_cycles = 0;
                in_valid  = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_hold", {62'd0, busy, done}, 64'd0);
                end
                rst = 1'b0;
                return;
            end
            // Junk traffic while not ready must be ignored by the feeder.
            if (j < total) begin
                in_valid = 1'($urandom);
                in_a     = $urandom;
                in_b     = $urandom;
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("done_count", 64'(dones), 64'd1);
        en_cycles += k + 1 + DRAIN;
`ifdef FEEDER_CYCLE_CNT_EN
        chk("cycle_cnt", 64'(cycle_cnt), 64'(en_cycles));
`endif
    endtask

    task automatic load_scenario1();
        ba0[0] = 16'd1; ba1[0] = 16'd3; bb0[0] = 16'd5; bb1[0] = 16'd6;
        ba0[1] = 16'd2; ba1[1] = 16'd4; bb0[1] = 16'd7; bb1[1] = 16'd8;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ops", {data_1, data_2, weight_1, weight_2}, 64'd0);
        chk("reset_ctrl", {59'd0, in_ready, systolic_en, busy, done, ovf}, 64'd0);
        rst = 1'b0;

        // Worked example: K=2, back-to-back beats.
        load_scenario1();
        run_set(2, 1'b1, 0, 0, 0);
        // Same set again, this time with in_valid pattern 1,0,0,1.
        load_scenario1();
        run_set(2, 1'b1, 2, 2, 0);
        // Single-beat set from IDLE.
        fill_random(1);
        run_set(1, 1'b1, 0, 1, 0);
        // Truncated set: DEPTH beats without last, then the next beat
        // starts a fresh one-beat set and clears ovf.
        fill_random(DEPTH);
        run_set(DEPTH, 1'b0, 0, 1, 0);
        fill_random(1);
        run_set(1, 1'b1, 0, 0, 0);
        // Reset during FEED at t=1, then a clean set.
        load_scenario1();
        run_set(2, 1'b1, 0, 0, 2);
        load_scenario1();
        run_set(2, 1'b1, 0, 1, 0);
        // Randomized sets.
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 4) == 0) begin
                fill_random(DEPTH);
                run_set(DEPTH, 1'b0, 0, 2, 0);
            end else begin
                int kk;
                kk = $urandom_range(1, DEPTH);
                fill_random(kk);
                run_set(kk, 1'b1, 0, 2, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
